// File: rtl/alu_pkg.sv
// Shared ALU definitions: lane-mode encodings, iteration counts and divider FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    VEC_B8  = 2'd0,
    VEC_H16 = 2'd1,
    VEC_W32 = 2'd2,
    VEC_D64 = 2'd3
  } vec_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int LANES_B8  = 4;
  localparam int LANES_H16 = 2;

  localparam logic [6:0] ITER_B8  = 7'd8;
  localparam logic [6:0] ITER_H16 = 7'd16;
  localparam logic [6:0] ITER_W32 = 7'd32;
  localparam logic [6:0] ITER_D64 = 7'd64;

  function automatic logic [6:0] iter_count(input vec_e v);
    case (v)
      VEC_B8:  iter_count = ITER_B8;
      VEC_H16: iter_count = ITER_H16;
      VEC_W32: iter_count = ITER_W32;
      VEC_D64: iter_count = ITER_D64;
      default: iter_count = ITER_D64;
    endcase
  endfunction

  // True when any divisor lane of the given mode is zero.
  function automatic logic lane_zero(input vec_e v, input logic [31:0] c);
    case (v)
      VEC_B8:  lane_zero = (c[7:0] == 8'h0) || (c[15:8] == 8'h0) ||
                           (c[23:16] == 8'h0) || (c[31:24] == 8'h0);
      VEC_H16: lane_zero = (c[15:0] == 16'h0) || (c[31:16] == 16'h0);
      default: lane_zero = (c == 32'h0);
    endcase
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step on every lane; lanes never exchange borrows.
module div_step
  import alu_pkg::*;
(
  input  vec_e        vec,
  input  logic [31:0] rem,
  input  logic [63:0] dq,
  input  logic [31:0] dvs,
  output logic [31:0] rem_nxt,
  output logic [63:0] dq_nxt
);

  // Returns {quotient bit, new remainder}; inputs are zero-extended lane values.
  function automatic logic [32:0] lane_step(input logic [31:0] r, input logic msb,
                                            input logic [31:0] d);
    logic [32:0] sh;
    logic        borrow;
    sh        = {r, msb};
    borrow    = (sh < {1'b0, d});
    lane_step = borrow ? {1'b0, sh[31:0]} : {1'b1, sh[31:0] - d};
  endfunction

  logic [32:0] step_s;

  // Per-mode lane extraction, trial subtraction and quotient-bit shift-in.
  always_comb begin
    rem_nxt = rem;
    dq_nxt  = dq;
    step_s  = 33'h0;
    case (vec)
      VEC_B8: begin
        for (int i = 0; i < LANES_B8; i++) begin
          step_s = lane_step({24'h0, rem[8*i +: 8]}, dq[8*i + 7], {24'h0, dvs[8*i +: 8]});
          rem_nxt[8*i +: 8] = step_s[7:0];
          dq_nxt[8*i +: 8]  = {dq[8*i +: 7], step_s[32]};
        end
      end
      VEC_H16: begin
        for (int i = 0; i < LANES_H16; i++) begin
          step_s = lane_step({16'h0, rem[16*i +: 16]}, dq[16*i + 15], {16'h0, dvs[16*i +: 16]});
          rem_nxt[16*i +: 16] = step_s[15:0];
          dq_nxt[16*i +: 16]  = {dq[16*i +: 15], step_s[32]};
        end
      end
      VEC_W32: begin
        step_s       = lane_step(rem, dq[31], dvs);
        rem_nxt      = step_s[31:0];
        dq_nxt[31:0] = {dq[30:0], step_s[32]};
      end
      VEC_D64: begin
        step_s  = lane_step(rem, dq[63], dvs);
        rem_nxt = step_s[31:0];
        dq_nxt  = {dq[62:0], step_s[32]};
      end
      default: begin
        step_s = 33'h0;
      end
    endcase
  end

endmodule

// File: rtl/simd_divider.sv
// Multi-cycle unsigned SIMD restoring divider with start/busy/done handshake.
module simd_divider
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  vec,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] C,
  input  logic [31:0] D,
  output logic [31:0] Y1,
  output logic [31:0] Y2,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic        ovf
);

  state_e      state_r, state_nxt_s;
  vec_e        vec_s, vec_r;
  logic        accept_s, last_s, dz_s, ovf_s;
  logic [6:0]  cnt_r;
  logic [63:0] dq_r, dq_nxt_s;
  logic [31:0] rem_r, rem_nxt_s, dvs_r;
  logic [31:0] y1_r, y2_r;
  logic        busy_r, done_r, dz_r, ovf_r;
  logic        unused_s;

  assign vec_s    = vec_e'(vec);
  assign dz_s     = lane_zero(vec_s, C);
  assign ovf_s    = (vec_s == VEC_D64) && (A >= C);
  assign unused_s = ^D;

  div_step u_step (
    .vec     (vec_r),
    .rem     (rem_r),
    .dq      (dq_r),
    .dvs     (dvs_r),
    .rem_nxt (rem_nxt_s),
    .dq_nxt  (dq_nxt_s)
  );

  // Next-state logic; a start seen during RUN is deliberately dropped.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 7'd1) begin
          last_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; overflow overrides the mode-3 result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      vec_r   <= VEC_B8;
      cnt_r   <= 7'd0;
      dq_r    <= 64'h0;
      rem_r   <= 32'h0;
      dvs_r   <= 32'h0;
      y1_r    <= 32'h0;
      y2_r    <= 32'h0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
      if (accept_s) begin
        vec_r <= vec_s;
        dvs_r <= C;
        dq_r  <= (vec_s == VEC_D64) ? {A, B} : {32'h0, A};
        rem_r <= 32'h0;
        cnt_r <= iter_count(vec_s);
        dz_r  <= dz_s;
        ovf_r <= ovf_s;
      end else if (state_r == RUN) begin
        dq_r  <= dq_nxt_s;
        rem_r <= rem_nxt_s;
        cnt_r <= cnt_r - 7'd1;
        if (last_s) begin
          y1_r <= ovf_r ? 32'hFFFF_FFFF : dq_nxt_s[31:0];
          y2_r <= ovf_r ? 32'h0 : rem_nxt_s;
        end
      end
    end
  end

  assign Y1   = y1_r;
  assign Y2   = y2_r;
  assign busy = busy_r;
  assign done = done_r;
  assign dz   = dz_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_simd_divider.sv
// Self-checking bench for simd_divider: directed table, handshake corners, random vs. arithmetic model.
module tb_simd_divider;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  vec;
  logic [31:0] A, B, C, D;
  logic [31:0] Y1, Y2;
  logic        busy, done, dz, ovf;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lat;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] a, b, c, y1, y2;
    logic        dz, ovf;
    int          lat;
  } vec_t;
  vec_t tbl[6];

  logic [1:0]  rv;
  logic [31:0] ra, rb, rc, ey1, ey2;
  logic        edz, eovf;
  logic [31:0] xa[3], xc[3];
  int          dcnt;

  always #5 clk = ~clk;

  simd_divider dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec),
    .A(A), .B(B), .C(C), .D(D),
    .Y1(Y1), .Y2(Y2), .busy(busy), .done(done), .dz(dz), .ovf(ovf)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain per-lane integer division from the lane rules.
  function automatic void model(input logic [1:0] v, input logic [31:0] a, b, c,
                                output logic [31:0] q, r, output logic z, o);
    longint unsigned w, mask, aa, cc, dd;
    q = 32'h0; r = 32'h0; z = 1'b0; o = 1'b0;
    if (v == 2'd3) begin
      z = (c == 32'h0);
      o = (a >= c);
      if (o) begin
        q = 32'hFFFF_FFFF;
        r = 32'h0;
      end else begin
        dd = {a, b};
        q  = 32'(dd / {32'h0, c});
        r  = 32'(dd % {32'h0, c});
      end
    end else begin
      w    = 64'd8 << v;
      mask = (64'd1 << w) - 64'd1;
      for (int i = 0; i < 32 / int'(w); i++) begin
        aa = ({32'h0, a} >> (i * w)) & mask;
        cc = ({32'h0, c} >> (i * w)) & mask;
        if (cc == 64'd0) begin
          z = 1'b1;
          q |= 32'(mask << (i * w));
          r |= 32'(aa << (i * w));
        end else begin
          q |= 32'((aa / cc) << (i * w));
          r |= 32'((aa % cc) << (i * w));
        end
      end
    end
  endfunction

  task automatic start_op(input logic [1:0] v, input logic [31:0] a, b, c);
    @(negedge clk);
    vec = v; A = a; B = b; C = c; D = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
  endtask

  task automatic wait_done();
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] v, input logic [31:0] a, b, c,
                           input logic [31:0] y1, y2, input logic z, o, input int n);
    start_op(v, a, b, c);
    check({tag, "_busy"}, busy, 1);
    wait_done();
    check({tag, "_lat"}, lat, n);
    check({tag, "_y1"}, Y1, y1);
    check({tag, "_y2"}, Y2, y2);
    check({tag, "_dz"}, dz, z);
    check({tag, "_ovf"}, ovf, o);
    @(negedge clk);
    check({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    tbl[0] = '{2'd0, 32'h640F_FF07, 32'h0, 32'h0A04_1000, 32'h0A03_0FFF, 32'h0003_0F07, 1'b1, 1'b0, 9};
    tbl[1] = '{2'd2, 32'd1000, 32'h0, 32'd7, 32'd142, 32'd6, 1'b0, 1'b0, 33};
    tbl[2] = '{2'd3, 32'h0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0, 1'b0, 65};
    tbl[3] = '{2'd3, 32'd5, 32'h0, 32'd5, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 65};
    tbl[4] = '{2'd1, 32'h0100_FFFF, 32'h1234_5678, 32'h0003_0000, 32'h0055_FFFF, 32'h0001_FFFF, 1'b1, 1'b0, 17};
    tbl[5] = '{2'd3, 32'h0, 32'h9, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 65};

    rst = 1'b1; start = 1'b0; vec = 2'd0; A = 32'h0; B = 32'h0; C = 32'h0; D = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_y1", Y1, 0);
    check("rst_y2", Y2, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", dz, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_check($sformatf("tbl%0d", i), tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c,
                tbl[i].y1, tbl[i].y2, tbl[i].dz, tbl[i].ovf, tbl[i].lat);

    // Reset during RUN: abort with all outputs cleared and no done.
    start_op(2'd1, 32'h8000_4000, 32'h0, 32'h0000_0005);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_y1", Y1, 0);
    check("abort_y2", Y2, 0);
    check("abort_dz", dz, 0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    run_check("after_abort", 2'd1, 32'h1000_0064, 32'h0, 32'h0010_000A,
              32'h0100_000A, 32'h0000_0000, 1'b0, 1'b0, 17);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; vec = 2'd0; A = 32'h1111_1111; C = 32'h0202_0202;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    @(negedge clk);
    check("rst_start_busy2", busy, 0);

    // Held start: back-to-back ops every 9 cycles, RUN-time operand changes ignored.
    for (int k = 0; k < 3; k++) begin
      xa[k] = $urandom;
      xc[k] = $urandom | 32'h0101_0101;
    end
    xc[1][15:8] = 8'h00;
    @(negedge clk);
    vec = 2'd0; A = xa[0]; C = xc[0]; B = $urandom; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      lat = 1;
      check($sformatf("b2b%0d_busy", k), busy, 1);
      A = $urandom; C = $urandom;
      @(negedge clk);
      lat = 2;
      if (k < 2) begin
        A = xa[k + 1]; C = xc[k + 1];
      end else begin
        start = 1'b0;
      end
      wait_done();
      model(2'd0, xa[k], 32'h0, xc[k], ey1, ey2, edz, eovf);
      check($sformatf("b2b%0d_lat", k), lat, 9);
      check($sformatf("b2b%0d_y1", k), Y1, ey1);
      check($sformatf("b2b%0d_y2", k), Y2, ey2);
      check($sformatf("b2b%0d_dz", k), dz, edz);
    end
    @(negedge clk);
    check("b2b_end_done", done, 0);
    check("b2b_end_busy", busy, 0);

    // Random operands in every mode against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      rv = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom; rc = $urandom;
      if ($urandom_range(0, 1) == 1) rc = rc >> $urandom_range(0, 31);
      if ($urandom_range(0, 4) == 0) rc[7:0] = 8'h00;
      if (rv == 2'd3 && rc != 32'h0 && $urandom_range(0, 3) != 0) ra = ra % rc;
      model(rv, ra, rb, rc, ey1, ey2, edz, eovf);
      run_check($sformatf("rnd%0d_m%0d", k, rv), rv, ra, rb, rc, ey1, ey2, edz, eovf,
                (8 << rv) + 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
